// File: rtl/acia_fifo.sv
// acia_fifo: MC6850-style 8N1 serial ACIA with a programmable bit divisor and
// TX/RX FIFOs, for the 6502 peripheral bus.
module acia_fifo #(
  parameter int CLK_FREQ     = 4000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       we_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(CLK_FREQ / DEFAULT_BAUD - 1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(15);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_HALF = CW'(FIFO_DEPTH / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic             r_rie;
  logic [1:0]       r_tc, r_cds;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_dout, r_last;
  logic             r_ovr, r_fe;

  logic w_wr, w_rd, w_wr_ctrl, w_wr_data, w_rd_data, w_soft, w_irq;
  logic [DIV_W-1:0] w_per, w_half;
  logic [7:0]       w_status;

  assign w_wr      = ~cs_n & ~we_n;
  assign w_rd      = ~cs_n & we_n;
  assign w_wr_ctrl = w_wr & (addr == 2'd0);
  assign w_wr_data = w_wr & (addr == 2'd1);
  assign w_rd_data = w_rd & (addr == 2'd1);
  // Soft reset also acts on the very edge that programs it.
  assign w_soft    = (r_cds == 2'b11) | (w_wr_ctrl & (din[1:0] == 2'b11));
  assign w_per     = (r_div < DIV_MIN) ? DIV_MIN : r_div;
  assign w_half    = {1'b0, w_per[DIV_W-1:1]} + DIV_W'(w_per[0]) - DIV_W'(1);

  // TX FIFO
  logic [7:0]    r_txm [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [7:0]    w_tx_head;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == CNT_FULL);
  assign w_tx_head  = r_txm[r_tx_rp];
  assign w_tx_push  = w_wr_data & (~w_tx_full | w_tx_pop) & ~w_soft;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_txm[r_tx_wp] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else if (w_soft) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  // RX FIFO
  logic [7:0]    r_rxm [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt;
  logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_push_ok, w_rx_pop, w_ovr_set, w_fe_set;
  logic [7:0]    w_rx_head;

  assign w_rx_empty   = (r_rx_cnt == '0);
  assign w_rx_full    = (r_rx_cnt == CNT_FULL);
  assign w_rx_head    = r_rxm[r_rx_rp];
  assign w_rx_pop     = w_rd_data & ~w_rx_empty & ~w_soft;
  assign w_rx_push_ok = w_rx_push & (~w_rx_full | w_rx_pop);
  assign w_ovr_set    = w_rx_push & w_rx_full & ~w_rx_pop;

  logic [7:0] r_rx_shift;

  always_ff @(posedge clk) begin
    if (w_rx_push_ok) r_rxm[r_rx_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else if (w_soft) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push_ok) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)     r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push_ok) - CW'(w_rx_pop);
    end
  end

  // TX FSM
  state_t           r_tx_state, w_tx_state_nx;
  logic [DIV_W-1:0] r_tx_bcnt, w_tx_bcnt_nx;
  logic [2:0]       r_tx_bit, w_tx_bit_nx;
  logic [7:0]       r_tx_shift, w_tx_shift_nx;
  logic             r_tx_line, w_tx_line_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= S_IDLE;
      r_tx_bcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_bcnt  <= w_tx_bcnt_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_line  <= w_tx_line_nx;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_bcnt_nx  = r_tx_bcnt;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_shift_nx = r_tx_shift;
    w_tx_line_nx  = r_tx_line;
    w_tx_pop      = 1'b0;
    if (w_soft) begin
      w_tx_state_nx = S_IDLE;
      w_tx_bcnt_nx  = '0;
      w_tx_bit_nx   = '0;
      w_tx_line_nx  = 1'b1;
    end else begin
      unique case (r_tx_state)
        S_IDLE: begin
          if (!w_tx_empty) begin
            w_tx_pop      = 1'b1;
            w_tx_state_nx = S_START;
            w_tx_shift_nx = w_tx_head;
            w_tx_bcnt_nx  = w_per;
            w_tx_line_nx  = 1'b0;
          end
        end
        S_START: begin
          if (r_tx_bcnt == '0) begin
            w_tx_state_nx = S_DATA;
            w_tx_line_nx  = r_tx_shift[0];
            w_tx_bcnt_nx  = w_per;
            w_tx_bit_nx   = '0;
          end else w_tx_bcnt_nx = r_tx_bcnt - DIV_W'(1);
        end
        S_DATA: begin
          if (r_tx_bcnt == '0) begin
            w_tx_bcnt_nx = w_per;
            if (r_tx_bit == 3'd7) begin
              w_tx_state_nx = S_STOP;
              w_tx_line_nx  = 1'b1;
            end else begin
              w_tx_bit_nx   = r_tx_bit + 3'd1;
              w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
              w_tx_line_nx  = r_tx_shift[1];
            end
          end else w_tx_bcnt_nx = r_tx_bcnt - DIV_W'(1);
        end
        S_STOP: begin
          if (r_tx_bcnt == '0) begin
            if (!w_tx_empty) begin
              w_tx_pop      = 1'b1;
              w_tx_state_nx = S_START;
              w_tx_shift_nx = w_tx_head;
              w_tx_bcnt_nx  = w_per;
              w_tx_line_nx  = 1'b0;
            end else w_tx_state_nx = S_IDLE;
          end else w_tx_bcnt_nx = r_tx_bcnt - DIV_W'(1);
        end
        default: w_tx_state_nx = S_IDLE;
      endcase
    end
  end

  // RX synchroniser and FSM
  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  state_t           r_rx_state, w_rx_state_nx;
  logic [DIV_W-1:0] r_rx_bcnt, w_rx_bcnt_nx;
  logic [2:0]       r_rx_bit, w_rx_bit_nx;
  logic [7:0]       w_rx_shift_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_bcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_state <= w_rx_state_nx;
      r_rx_bcnt  <= w_rx_bcnt_nx;
      r_rx_bit   <= w_rx_bit_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_bcnt_nx  = r_rx_bcnt;
    w_rx_bit_nx   = r_rx_bit;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push     = 1'b0;
    w_fe_set      = 1'b0;
    if (w_soft) begin
      w_rx_state_nx = S_IDLE;
      w_rx_bcnt_nx  = '0;
      w_rx_bit_nx   = '0;
    end else begin
      unique case (r_rx_state)
        S_IDLE: begin
          if (r_rx_s3 & ~r_rx_s2) begin
            w_rx_state_nx = S_START;
            w_rx_bcnt_nx  = w_half;
          end
        end
        S_START: begin
          if (r_rx_bcnt == '0) begin
            if (r_rx_s2) w_rx_state_nx = S_IDLE;
            else begin
              w_rx_state_nx = S_DATA;
              w_rx_bcnt_nx  = w_per;
              w_rx_bit_nx   = '0;
            end
          end else w_rx_bcnt_nx = r_rx_bcnt - DIV_W'(1);
        end
        S_DATA: begin
          if (r_rx_bcnt == '0) begin
            w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
            w_rx_bcnt_nx  = w_per;
            if (r_rx_bit == 3'd7) w_rx_state_nx = S_STOP;
            else w_rx_bit_nx = r_rx_bit + 3'd1;
          end else w_rx_bcnt_nx = r_rx_bcnt - DIV_W'(1);
        end
        S_STOP: begin
          if (r_rx_bcnt == '0) begin
            w_rx_push     = 1'b1;
            w_fe_set      = ~r_rx_s2;
            w_rx_state_nx = S_IDLE;
          end else w_rx_bcnt_nx = r_rx_bcnt - DIV_W'(1);
        end
        default: w_rx_state_nx = S_IDLE;
      endcase
    end
  end

  // Control, divisor, flags, read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rie <= 1'b0;
      r_tc  <= '0;
      r_cds <= '0;
      r_div <= DIV_RST;
    end else if (w_wr) begin
      unique case (addr)
        2'd0: begin
          r_rie <= din[7];
          r_tc  <= din[6:5];
          r_cds <= din[1:0];
        end
        2'd2:    r_div[7:0]       <= din;
        2'd3:    r_div[DIV_W-1:8] <= din[DIV_W-9:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovr <= 1'b0;
      r_fe  <= 1'b0;
    end else if (w_soft) begin
      r_ovr <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      if (w_rd_data) begin
        r_ovr <= 1'b0;
        r_fe  <= 1'b0;
      end
      if (w_ovr_set) r_ovr <= 1'b1;
      if (w_fe_set)  r_fe  <= 1'b1;
    end
  end

  assign w_irq    = (r_rie & (~w_rx_empty | r_ovr)) | ((r_tc == 2'b01) & ~w_tx_full);
  assign w_status = {w_irq, 1'b0, r_ovr, r_fe, (r_rx_cnt >= CNT_HALF), w_tx_full, ~w_tx_full, ~w_rx_empty};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
      r_last <= '0;
    end else begin
      if (w_rx_pop) r_last <= w_rx_head;
      if (w_rd) begin
        unique case (addr)
          2'd0:    r_dout <= w_status;
          2'd1:    r_dout <= w_rx_pop ? w_rx_head : r_last;
          2'd2:    r_dout <= r_div[7:0];
          default: r_dout <= 8'(r_div[DIV_W-1:8]);
        endcase
      end
    end
  end

  assign dout  = r_dout;
  assign tx    = r_tx_line;
  assign irq_n = ~w_irq;

endmodule

// File: tb/tb_acia_fifo.sv
// Directed/randomised bench for acia_fifo with a queue-based reference model
// of the RX FIFO, flags and interrupt, and a serial frame decoder for tx.
module tb_acia_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n, cs_n, we_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       tx, irq_n, rx_w;
  logic       loop, rx_drv;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_rxq[$];
  logic [7:0] m_last, m_ctrl;
  logic       m_ovr, m_fe;

  assign rx_w = loop ? tx : rx_drv;

  acia_fifo #(.CLK_FREQ(4000000), .DEFAULT_BAUD(9600), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .din(din),
    .dout(dout), .rx(rx_w), .tx(tx), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_irq();
    return (m_ctrl[7] & ((m_rxq.size() != 0) | m_ovr)) | (m_ctrl[6:5] == 2'b01);
  endfunction

  function automatic logic [7:0] exp_status();
    int c = m_rxq.size();
    return {exp_irq(), 1'b0, m_ovr, m_fe, (c >= DEPTH / 2), 1'b0, 1'b1, (c != 0)};
  endfunction

  task automatic model_push(input logic [7:0] b, input logic stop);
    if (m_rxq.size() == DEPTH) m_ovr = 1'b1;
    else m_rxq.push_back(b);
    if (!stop) m_fe = 1'b1;
  endtask

  task automatic model_pop(output logic [7:0] e);
    if (m_rxq.size() > 0) begin
      e = m_rxq.pop_front();
      m_last = e;
    end else e = m_last;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic model_clear();
    m_rxq.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs_n = 1'b1; we_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b1; addr = a;
    @(negedge clk);
    cs_n = 1'b1;
    d = dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = stop;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  task automatic wait_tx_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 400);
    check("tx_start_seen", {7'b0, tx}, 8'h00);
  endtask

  // Called on the first sample of a start bit; returns after the stop-bit centre.
  task automatic capture(output logic [7:0] b);
    repeat (8) @(negedge clk);
    check("tx_start_mid", {7'b0, tx}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      repeat (16) @(negedge clk);
      b[k] = tx;
    end
    repeat (16) @(negedge clk);
    check("tx_stop_mid", {7'b0, tx}, 8'h01);
  endtask

  initial begin
    logic [7:0] r, e, b, cap;
    int bad;
    reset_n = 1'b0; cs_n = 1'b1; we_n = 1'b1; addr = '0; din = '0;
    loop = 1'b0; rx_drv = 1'b1;
    m_last = '0; m_ctrl = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state and default divisor
    check("rst_dout", dout, 8'h00);
    check("rst_tx", {7'b0, tx}, 8'h01);
    check("rst_irq_n", {7'b0, irq_n}, 8'h01);
    bus_rd(2'd0, r); check("rst_status", r, exp_status());
    bus_rd(2'd2, r); check("rst_div_lo", r, 8'h9F);
    bus_rd(2'd3, r); check("rst_div_hi", r, 8'h01);

    // Back-to-back frames at 16 clk per bit
    bus_wr(2'd2, 8'd15);
    bus_wr(2'd3, 8'd0);
    fork
      begin
        bus_wr(2'd1, 8'hA5);
        bus_wr(2'd1, 8'h3C);
      end
      begin
        wait_tx_start();
        capture(cap); check("frame0", cap, 8'hA5);
        repeat (8) @(negedge clk);
        check("tx_no_gap", {7'b0, tx}, 8'h00);
        capture(cap); check("frame1", cap, 8'h3C);
      end
    join
    repeat (40) @(negedge clk);

    // Divisor below 15 still gives 16-clock bits
    bus_wr(2'd2, 8'd4);
    bus_rd(2'd2, r); check("div_small_rd", r, 8'h04);
    b = 8'($urandom);
    fork
      bus_wr(2'd1, b);
      begin
        wait_tx_start();
        capture(cap); check("frame_clamped", cap, b);
      end
    join
    bus_wr(2'd2, 8'd15);
    repeat (40) @(negedge clk);

    // Loopback overflow: FIFO_DEPTH+1 random bytes, no reads
    loop = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      bus_wr(2'd1, b);
      model_push(b, 1'b1);
    end
    repeat ((DEPTH + 1) * 160 + 300) @(negedge clk);
    bus_rd(2'd0, r); check("ovr_status", r, exp_status());
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(2'd1, r); model_pop(e); check("loop_data", r, e);
    end
    bus_rd(2'd0, r); check("drained_status", r, exp_status());
    bus_rd(2'd1, r); model_pop(e); check("empty_read_last", r, e);
    loop = 1'b0;
    repeat (40) @(negedge clk);

    // Plain receive, false start, framing error
    b = 8'($urandom);
    send_rx(b, 1'b1); model_push(b, 1'b1);
    bus_rd(2'd0, r); check("rx1_status", r, exp_status());
    bus_rd(2'd1, r); model_pop(e); check("rx1_data", r, e);
    @(negedge clk); rx_drv = 1'b0;
    repeat (3) @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(2'd0, r); check("false_start_status", r, exp_status());
    b = 8'($urandom);
    send_rx(b, 1'b0); model_push(b, 1'b0);
    bus_rd(2'd0, r); check("fe_status", r, exp_status());
    bus_rd(2'd1, r); model_pop(e); check("fe_data", r, e);
    bus_rd(2'd0, r); check("fe_cleared_status", r, exp_status());

    // Interrupt sources
    bus_wr(2'd0, 8'h80); m_ctrl = 8'h80;
    check("irq_rie_idle", {7'b0, irq_n}, {7'b0, ~exp_irq()});
    b = 8'($urandom);
    send_rx(b, 1'b1); model_push(b, 1'b1);
    check("irq_rx", {7'b0, irq_n}, {7'b0, ~exp_irq()});
    bus_rd(2'd1, r); model_pop(e); check("irq_rx_data", r, e);
    check("irq_rx_cleared", {7'b0, irq_n}, {7'b0, ~exp_irq()});
    bus_wr(2'd0, 8'h20); m_ctrl = 8'h20;
    check("irq_tc", {7'b0, irq_n}, {7'b0, ~exp_irq()});

    // Soft reset mid-frame with both FIFOs occupied
    b = 8'($urandom);
    send_rx(b, 1'b1); model_push(b, 1'b1);
    bus_wr(2'd1, 8'($urandom));
    bus_wr(2'd1, 8'($urandom));
    bus_wr(2'd1, 8'($urandom));
    repeat (40) @(negedge clk);
    bus_wr(2'd0, 8'h03); m_ctrl = 8'h03; model_clear();
    check("soft_tx", {7'b0, tx}, 8'h01);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("soft_tx_held", 8'(bad), 8'h00);
    bus_rd(2'd0, r); check("soft_status", r, exp_status());
    bus_rd(2'd2, r); check("soft_div_kept", r, 8'h0F);
    bus_wr(2'd0, 8'h20); m_ctrl = 8'h20;
    bus_rd(2'd0, r); check("post_soft_status", r, exp_status());

    // Asynchronous hard reset mid-frame
    bus_wr(2'd1, 8'h00);
    bus_wr(2'd1, 8'h00);
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_tx", {7'b0, tx}, 8'h01);
    check("arst_dout", dout, 8'h00);
    check("arst_irq_n", {7'b0, irq_n}, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    m_ctrl = '0; model_clear();
    bus_rd(2'd0, r); check("arst_status", r, exp_status());
    bus_rd(2'd2, r); check("arst_div_lo", r, 8'h9F);
    bus_rd(2'd3, r); check("arst_div_hi", r, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
